// File: rtl/program_loader_if.sv
// Byte-stream input, instruction-memory write port and session status of the program loader.
interface program_loader_if;
  logic        start;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wd;
  logic        core_hold;
  logic        busy;
  logic        done;
  logic        error;
  logic [15:0] word_count;

  modport slave (
    input  start, in_valid, in_data,
    output in_ready, mem_we, mem_addr, mem_wd, core_hold, busy, done, error, word_count
  );

  modport master (
    output start, in_valid, in_data,
    input  in_ready, mem_we, mem_addr, mem_wd, core_hold, busy, done, error, word_count
  );
endinterface

// File: rtl/program_loader.sv
// Loads a length-prefixed, XOR-checksummed byte stream into instruction memory and
// keeps the core held in reset until a complete image has been verified.
module program_loader #(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int unsigned DEPTH_WORDS = 256
) (
  input logic             clk,
  input logic             rst,
  program_loader_if.slave bus
);

  typedef enum logic [2:0] {IDLE, LEN_LO, LEN_HI, DATA, CSUM, DONE, ERR} state_t;

  state_t      state;
  state_t      state_nxt;
  logic [15:0] len;
  logic [1:0]  byte_idx;
  logic [7:0]  csum;
  logic [23:0] word_buf;
  logic [15:0] word_count;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wd;
  logic        in_ready;
  logic        busy;
  logic        done;
  logic        error;
  logic        core_hold;
  logic        accept;
  logic        session_start;
  logic [15:0] len_in;

  assign accept        = bus.in_valid && in_ready;
  assign session_start = (state == IDLE || state == DONE || state == ERR) && bus.start;
  assign len_in        = {bus.in_data, len[7:0]};

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE, ERR: if (bus.start) state_nxt = LEN_LO;
      LEN_LO:          if (accept) state_nxt = LEN_HI;
      LEN_HI: begin
        if (accept) begin
          if (32'(len_in) > DEPTH_WORDS) state_nxt = ERR;
          else if (len_in == 16'd0)      state_nxt = CSUM;
          else                           state_nxt = DATA;
        end
      end
      DATA: begin
        if (accept && byte_idx == 2'd3)
          state_nxt = (word_count + 16'd1 == len) ? CSUM : DATA;
      end
      CSUM:    if (accept) state_nxt = (bus.in_data == csum) ? DONE : ERR;
      default: state_nxt = IDLE;
    endcase
  end

  // Status flags are registered from the next state so they change together with it.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      in_ready   <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      error      <= 1'b0;
      core_hold  <= 1'b1;
      mem_we     <= 1'b0;
      mem_addr   <= BASE_ADDR;
      mem_wd     <= 32'd0;
      word_count <= 16'd0;
      len        <= 16'd0;
      byte_idx   <= 2'd0;
      csum       <= 8'd0;
      word_buf   <= 24'd0;
    end else begin
      state     <= state_nxt;
      in_ready  <= state_nxt inside {LEN_LO, LEN_HI, DATA, CSUM};
      busy      <= state_nxt inside {LEN_LO, LEN_HI, DATA, CSUM};
      done      <= (state_nxt == DONE);
      error     <= (state_nxt == ERR);
      core_hold <= (state_nxt != DONE);
      mem_we    <= 1'b0;

      if (session_start) begin
        word_count <= 16'd0;
        byte_idx   <= 2'd0;
        csum       <= 8'd0;
      end

      if (accept) begin
        csum <= csum ^ bus.in_data;
        case (state)
          LEN_LO: len[7:0]  <= bus.in_data;
          LEN_HI: len[15:8] <= bus.in_data;
          DATA: begin
            byte_idx <= byte_idx + 2'd1;
            case (byte_idx)
              2'd0: word_buf[7:0]   <= bus.in_data;
              2'd1: word_buf[15:8]  <= bus.in_data;
              2'd2: word_buf[23:16] <= bus.in_data;
              default: begin
                mem_we     <= 1'b1;
                mem_wd     <= {bus.in_data, word_buf};
                mem_addr   <= BASE_ADDR + {14'd0, word_count, 2'b00};
                word_count <= word_count + 16'd1;
              end
            endcase
          end
          default: ;
        endcase
      end
    end
  end

  assign bus.in_ready   = in_ready;
  assign bus.busy       = busy;
  assign bus.done       = done;
  assign bus.error      = error;
  assign bus.core_hold  = core_hold;
  assign bus.mem_we     = mem_we;
  assign bus.mem_addr   = mem_addr;
  assign bus.mem_wd     = mem_wd;
  assign bus.word_count = word_count;

endmodule

// File: tb/tb_program_loader.sv
// Scoreboard bench for program_loader: stimulus pushes expected writes/results, a monitor checks them.
module tb_program_loader;
  localparam logic [31:0] BASE  = 32'h0000_0000;
  localparam int          DEPTH = 256;

  typedef logic [31:0] wq_t[$];
  typedef struct { logic [31:0] addr; logic [31:0] data; logic [15:0] wc; } wr_t;
  typedef struct { logic done; logic err; logic [15:0] wc; } res_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  program_loader_if bus();

  program_loader #(.BASE_ADDR(BASE), .DEPTH_WORDS(DEPTH)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  wr_t  exp_wr[$];
  res_t exp_res[$];
  int   errors = 0;
  int   checks = 0;
  bit   gaps = 0;
  bit   poke = 0;
  logic prev_busy = 1'b0;
  wr_t  mw;
  res_t mr;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_in_ready"},   32'(bus.in_ready),   32'd0);
    chk({tag, "_mem_we"},     32'(bus.mem_we),     32'd0);
    chk({tag, "_mem_addr"},   bus.mem_addr,        BASE);
    chk({tag, "_mem_wd"},     bus.mem_wd,          32'd0);
    chk({tag, "_core_hold"},  32'(bus.core_hold),  32'd1);
    chk({tag, "_busy"},       32'(bus.busy),       32'd0);
    chk({tag, "_done"},       32'(bus.done),       32'd0);
    chk({tag, "_error"},      32'(bus.error),      32'd0);
    chk({tag, "_word_count"}, 32'(bus.word_count), 32'd0);
  endtask

  // Monitor: every write and every session end is matched against the scoreboard.
  always @(negedge clk) begin
    if (bus.mem_we) begin
      if (exp_wr.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: got addr 0x%08h data 0x%08h, required no write", bus.mem_addr, bus.mem_wd);
      end else begin
        mw = exp_wr.pop_front();
        chk("wr_addr", bus.mem_addr, mw.addr);
        chk("wr_data", bus.mem_wd, mw.data);
        chk("wr_count", 32'(bus.word_count), 32'(mw.wc));
      end
    end
    if (prev_busy && !bus.busy && !rst) begin
      if (exp_res.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_end: got done=%0d error=%0d, required a running session", bus.done, bus.error);
      end else begin
        mr = exp_res.pop_front();
        chk("res_done", 32'(bus.done), 32'(mr.done));
        chk("res_error", 32'(bus.error), 32'(mr.err));
        chk("res_core_hold", 32'(bus.core_hold), 32'(!mr.done));
        chk("res_in_ready", 32'(bus.in_ready), 32'd0);
        chk("res_word_count", 32'(bus.word_count), 32'(mr.wc));
      end
    end
    prev_busy = bus.busy;
  end

  task automatic send_byte(input logic [7:0] b);
    bit acc = 0;
    for (int i = 0; i < 200 && !acc; i++) begin
      bus.in_valid = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
      bus.in_data  = bus.in_valid ? b : 8'($urandom);
      bus.start    = poke && ($urandom_range(0, 5) == 0);
      @(negedge clk);
      acc = bus.in_valid && bus.in_ready;
      @(posedge clk);
      #1;
    end
    bus.in_valid = 1'b0;
    bus.start    = 1'b0;
    if (!acc) chk("byte_accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic start_session();
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
  endtask

  // Reference: word k lands at BASE+4k; session succeeds iff the checksum byte equals the XOR of all before it.
  task automatic run_load(input wq_t w, input logic [7:0] corrupt);
    logic [15:0] n;
    logic [7:0]  x;
    n = 16'(w.size());
    x = n[7:0] ^ n[15:8];
    start_session();
    send_byte(n[7:0]);
    send_byte(n[15:8]);
    foreach (w[k]) begin
      for (int j = 0; j < 4; j++) begin
        logic [7:0] b;
        b = w[k][8*j +: 8];
        x = x ^ b;
        if (j == 3) exp_wr.push_back('{BASE + 32'(4 * k), w[k], 16'(k + 1)});
        send_byte(b);
      end
    end
    exp_res.push_back('{(corrupt == 8'd0), (corrupt != 8'd0), n});
    send_byte(x ^ corrupt);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    wq_t ws;
    wq_t normal;
    normal = '{32'h00A0_0513, 32'h00B0_0593};
    rst = 1'b1;
    bus.start = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data = 8'h00;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset_vals("reset");
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;

    run_load(normal, 8'h00);
    ws.delete();
    run_load(ws, 8'h00);
    run_load(normal, 8'h01);

    // Oversize length is rejected immediately after the high length byte.
    start_session();
    exp_res.push_back('{1'b0, 1'b1, 16'd0});
    send_byte(8'h01);
    send_byte(8'h01);
    chk("oversize_in_ready", 32'(bus.in_ready), 32'd0);
    chk("oversize_error", 32'(bus.error), 32'd1);
    @(posedge clk);
    #1;

    gaps = 1;
    poke = 1;
    run_load(normal, 8'h00);
    gaps = 0;
    poke = 0;

    // Reset arrives together with the 4th byte of word 1: that write must not happen.
    start_session();
    send_byte(8'h02);
    send_byte(8'h00);
    exp_wr.push_back('{BASE, 32'h00A0_0513, 16'd1});
    send_byte(8'h13); send_byte(8'h05); send_byte(8'hA0); send_byte(8'h00);
    send_byte(8'h93); send_byte(8'h05); send_byte(8'hB0);
    bus.in_valid = 1'b1;
    bus.in_data  = 8'h00;
    bus.start    = 1'b1;
    rst          = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.start    = 1'b0;
    @(negedge clk);
    check_reset_vals("midrst");
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("start_with_rst_ignored", 32'(bus.busy), 32'd0);
    @(posedge clk);
    #1;
    run_load(normal, 8'h00);

    for (int s = 0; s < 6; s++) begin
      int n;
      logic [7:0] c;
      ws.delete();
      n = $urandom_range(0, 8);
      for (int k = 0; k < n; k++) ws.push_back($urandom);
      c = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 255)) : 8'h00;
      gaps = ($urandom_range(0, 1) == 1);
      poke = ($urandom_range(0, 1) == 1);
      run_load(ws, c);
    end
    gaps = 0;
    poke = 0;

    ws.delete();
    for (int k = 0; k < DEPTH; k++) ws.push_back($urandom);
    run_load(ws, 8'h00);

    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("pending_writes", 32'(exp_wr.size()), 32'd0);
    chk("pending_results", 32'(exp_res.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
